// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with whole-line refill over a req/ack port.
// Define ICACHE_STATS_EN to add the hit_count/miss_count statistics ports.
module icache #(
    parameter int unsigned LINES = 16,
    parameter int unsigned WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] instr,
    output logic        stall,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int unsigned OFF_W  = $clog2(WORDS);
    localparam int unsigned IDX_W  = $clog2(LINES);
    localparam int unsigned LINE_W = 30 - OFF_W;
    localparam int unsigned TAG_W  = LINE_W - IDX_W;

    typedef enum logic {StIdle, StRefill} state_e;

    state_e state_q, state_d;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [31:0]       data_mem [LINES][WORDS];

    logic [LINE_W-1:0] line_q;
    logic [OFF_W-1:0]  cnt_q;
    logic              flush_seen_q;
    logic              mem_req_q;
    logic [31:0]       mem_addr_q;

    logic [OFF_W-1:0]  pc_off;
    logic [IDX_W-1:0]  pc_idx;
    logic [TAG_W-1:0]  pc_tag;
    logic [LINE_W-1:0] pc_line;
    logic [IDX_W-1:0]  ref_idx;
    logic [TAG_W-1:0]  ref_tag;
    logic              hit;
    logic              miss_start;
    logic              xfer;
    logic              last_word;
    logic              refill_done;
    logic              unused_pc;

    assign pc_off    = pc[OFF_W+1:2];
    assign pc_idx    = pc[OFF_W+2 +: IDX_W];
    assign pc_tag    = pc[31 -: TAG_W];
    assign pc_line   = pc[31:OFF_W+2];
    assign unused_pc = ^pc[1:0];

    assign ref_idx = line_q[IDX_W-1:0];
    assign ref_tag = line_q[LINE_W-1 -: TAG_W];

    assign hit         = valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);
    // A flush in the same cycle as a miss suppresses the refill.
    assign miss_start  = (state_q == StIdle) && !hit && !flush;
    assign xfer        = (state_q == StRefill) && mem_req_q && mem_ack;
    assign last_word   = (cnt_q == OFF_W'(WORDS - 1));
    assign refill_done = xfer && last_word;

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (miss_start) begin
                    state_d = StRefill;
                end
            end
            StRefill: begin
                if (refill_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: hits are served combinationally, everything else stalls with a NOP
    always_comb begin
        stall = 1'b1;
        instr = 32'h0000_0000;
        unique case (state_q)
            StIdle: begin
                if (hit) begin
                    stall = 1'b0;
                    instr = data_mem[pc_idx][pc_off];
                end
            end
            StRefill: begin
                stall = 1'b1;
            end
            default: stall = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= '0;
            line_q       <= '0;
            cnt_q        <= '0;
            flush_seen_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            if (miss_start) begin
                line_q       <= pc_line;
                cnt_q        <= '0;
                flush_seen_q <= 1'b0;
                mem_req_q    <= 1'b1;
                mem_addr_q   <= {pc_line, {(OFF_W + 2){1'b0}}};
            end

            if (xfer) begin
                cnt_q      <= cnt_q + OFF_W'(1);
                mem_addr_q <= {line_q, cnt_q + OFF_W'(1), 2'b00};
                if (last_word) begin
                    mem_req_q <= 1'b0;
                end
            end

            if ((state_q == StRefill) && flush) begin
                flush_seen_q <= 1'b1;
            end

            // Later assignments take priority: flush clears everything last.
            if (miss_start) begin
                valid_q[pc_idx] <= 1'b0;
            end
            if (refill_done && !flush_seen_q && !flush) begin
                valid_q[ref_idx] <= 1'b1;
            end
            if (flush) begin
                valid_q <= '0;
            end
        end
    end

    // Tag and data arrays carry no reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (xfer) begin
            data_mem[ref_idx][cnt_q] <= mem_rdata;
            if (last_word) begin
                tag_mem[ref_idx] <= ref_tag;
            end
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if ((state_q == StIdle) && hit) begin
                hit_count <= hit_count + 32'd1;
            end
            if (miss_start) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`else
    // Statistics disabled: no counters are built.
`endif

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache: miss/hit timing, slow memory, flush and reset.
// Statistics checks are compiled only when ICACHE_STATS_EN is defined.
module tb_icache;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        stall;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    logic        slow;
    int          wait_cnt;
    int          checks;
    int          errors;
    logic [31:0] addr_log[$];
    logic [31:0] req_log[$];

    icache #(
        .LINES(16),
        .WORDS(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .instr     (instr),
        .stall     (stall),
        .flush     (flush),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word k holds 0xA000_0000 + k; slow mode acks on the 3rd request cycle.
    assign mem_rdata = 32'hA000_0000 + {2'b00, mem_addr[31:2]};
    assign mem_ack   = slow ? (wait_cnt == 2) : 1'b1;

    always @(posedge clk) begin
        if (!mem_req || mem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    // Presents a pc at a falling edge and runs until the hit; returns stall cycles (-1 on timeout).
    task automatic fetch(input logic [31:0] a, output int cyc, output logic [31:0] ins);
        bit done;
        done = 0;
        cyc  = 0;
        ins  = 32'hx;
        addr_log.delete();
        req_log.delete();
        pc = a;
        for (int i = 0; i < 64; i++) begin
            #1;
            if (!stall) begin
                ins  = instr;
                done = 1;
                @(negedge clk);
                break;
            end
            cyc++;
            if (mem_req) req_log.push_back(mem_addr);
            if (mem_req && mem_ack) addr_log.push_back(mem_addr);
            @(negedge clk);
        end
        if (!done) cyc = -1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL reset_stall got %b want 1", stall);
        end
        checks++;
        if (instr !== 32'h0) begin
            errors++; $display("FAIL reset_instr got %h want 00000000", instr);
        end
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
            errors++; $display("FAIL reset_mem got req=%b addr=%h want req=0 addr=0", mem_req, mem_addr);
        end
`ifdef ICACHE_STATS_EN
        checks++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            errors++; $display("FAIL reset_stats got %0d/%0d want 0/0", hit_count, miss_count);
        end
`endif
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_cold_miss();
        int cyc;
        logic [31:0] ins;
        fetch(32'h0, cyc, ins);
        checks++;
        if (cyc != 5) begin
            errors++; $display("FAIL cold_stall_cycles got %0d want 5", cyc);
        end
        checks++;
        if (addr_log.size() != 4) begin
            errors++; $display("FAIL cold_num_req got %0d want 4", addr_log.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (addr_log[k] !== 32'(4 * k)) begin
                    errors++; $display("FAIL cold_addr%0d got %h want %h", k, addr_log[k], 32'(4 * k));
                end
            end
        end
        checks++;
        if (ins !== 32'hA000_0000) begin
            errors++; $display("FAIL cold_instr got %h want a0000000", ins);
        end
    endtask

    task automatic test_hit();
        pc = 32'h8;
        #1;
        checks++;
        if (instr !== 32'hA000_0002 || stall !== 1'b0) begin
            errors++; $display("FAIL hit_same_line got instr=%h stall=%b want a0000002/0", instr, stall);
        end
        checks++;
        if (mem_req !== 1'b0) begin
            errors++; $display("FAIL hit_no_req got %b want 0", mem_req);
        end
        @(negedge clk);
    endtask

    task automatic test_conflict();
        int cyc;
        logic [31:0] ins;
        fetch(32'h100, cyc, ins);
        checks++;
        if (cyc != 5 || addr_log.size() != 4) begin
            errors++; $display("FAIL conflict_cycles got %0d/%0d want 5/4", cyc, addr_log.size());
        end else begin
            checks++;
            if (addr_log[0] !== 32'h100 || addr_log[3] !== 32'h10C) begin
                errors++; $display("FAIL conflict_addr got %h..%h want 100..10c", addr_log[0], addr_log[3]);
            end
        end
        checks++;
        if (ins !== 32'hA000_0040) begin
            errors++; $display("FAIL conflict_instr got %h want a0000040", ins);
        end
        fetch(32'h0, cyc, ins);
        checks++;
        if (cyc != 5 || addr_log.size() != 4) begin
            errors++; $display("FAIL refetch_cycles got %0d/%0d want 5/4", cyc, addr_log.size());
        end else begin
            checks++;
            if (addr_log[0] !== 32'h0 || addr_log[3] !== 32'hC) begin
                errors++; $display("FAIL refetch_addr got %h..%h want 0..c", addr_log[0], addr_log[3]);
            end
        end
        checks++;
        if (ins !== 32'hA000_0000) begin
            errors++; $display("FAIL refetch_instr got %h want a0000000", ins);
        end
    endtask

    task automatic test_slow_memory();
        int cyc;
        logic [31:0] ins;
        slow = 1'b1;
        fetch(32'h24, cyc, ins);
        slow = 1'b0;
        checks++;
        if (cyc != 13) begin
            errors++; $display("FAIL slow_stall_cycles got %0d want 13", cyc);
        end
        checks++;
        if (req_log.size() != 12) begin
            errors++; $display("FAIL slow_req_cycles got %0d want 12", req_log.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                checks++;
                if (req_log[i] !== 32'h20 + 32'(4 * (i / 3))) begin
                    errors++;
                    $display("FAIL slow_addr_stable%0d got %h want %h", i, req_log[i],
                             32'h20 + 32'(4 * (i / 3)));
                end
            end
        end
        checks++;
        if (ins !== 32'hA000_0009) begin
            errors++; $display("FAIL slow_instr got %h want a0000009", ins);
        end
    endtask

    task automatic test_flush_mid_refill();
        int cyc;
        int hs;
        logic [31:0] ins;
        hs = 0;
        pc = 32'h40;
        for (int c = 0; c <= 6; c++) begin
            flush = (c == 2);
            #1;
            if (c <= 4 && mem_req && mem_ack) hs++;
            if (c == 5) begin
                checks++;
                if (stall !== 1'b1 || mem_req !== 1'b0) begin
                    errors++; $display("FAIL flush_line_invalid got stall=%b req=%b want 1/0", stall, mem_req);
                end
            end
            if (c == 6) begin
                checks++;
                if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin
                    errors++; $display("FAIL flush_rerefill got req=%b addr=%h want 1/40", mem_req, mem_addr);
                end
            end
            @(negedge clk);
        end
        flush = 1'b0;
        checks++;
        if (hs != 4) begin
            errors++; $display("FAIL flush_handshakes got %0d want 4", hs);
        end
        fetch(32'h40, cyc, ins);
        checks++;
        if (cyc < 0 || ins !== 32'hA000_0010) begin
            errors++; $display("FAIL flush_refill_instr got %h (cyc %0d) want a0000010", ins, cyc);
        end
    endtask

    task automatic test_flush_idle_miss();
        int cyc;
        logic [31:0] ins;
        pc = 32'h80;
        flush = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL flush_idle_stall got %b want 1", stall);
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++; $display("FAIL flush_wins got req=%b want 0", mem_req);
        end
        fetch(32'h80, cyc, ins);
        checks++;
        if (cyc != 5 || ins !== 32'hA000_0020) begin
            errors++; $display("FAIL flush_idle_refetch got cyc=%0d instr=%h want 5/a0000020", cyc, ins);
        end
    endtask

    task automatic test_reset_mid_refill();
        int cyc;
        logic [31:0] ins;
        pc = 32'hC0;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'hCC) begin
            errors++; $display("FAIL pre_reset_req got req=%b addr=%h want 1/cc", mem_req, mem_addr);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
            errors++; $display("FAIL reset_mid_mem got req=%b addr=%h want 0/0", mem_req, mem_addr);
        end
        checks++;
        if (stall !== 1'b1 || instr !== 32'h0) begin
            errors++; $display("FAIL reset_mid_out got stall=%b instr=%h want 1/0", stall, instr);
        end
        @(negedge clk);
        reset = 1'b0;
        fetch(32'hC0, cyc, ins);
        checks++;
        if (cyc != 5 || addr_log.size() != 4 || ins !== 32'hA000_0030) begin
            errors++; $display("FAIL reset_mid_refetch got cyc=%0d n=%0d instr=%h want 5/4/a0000030",
                               cyc, addr_log.size(), ins);
        end
        fetch(32'h40, cyc, ins);
        checks++;
        if (cyc != 5) begin
            errors++; $display("FAIL reset_invalidates got %0d want 5", cyc);
        end
    endtask

`ifdef ICACHE_STATS_EN
    task automatic test_stats();
        int cyc;
        logic [31:0] ins;
        reset = 1'b1;
        pc = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        fetch(32'h0, cyc, ins);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (miss_count !== 32'd1 || hit_count !== 32'd3) begin
            errors++; $display("FAIL stats_counts got miss=%0d hit=%0d want 1/3", miss_count, hit_count);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (miss_count !== 32'd0 || hit_count !== 32'd0) begin
            errors++; $display("FAIL stats_reset got miss=%0d hit=%0d want 0/0", miss_count, hit_count);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        pc     = 32'h0;
        flush  = 1'b0;
        slow   = 1'b0;
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_slow_memory();
        test_flush_mid_refill();
        test_flush_idle_miss();
        test_reset_mid_refill();
`ifdef ICACHE_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the pipelined MIPS core's fetch port (`pc`/`instr`) and a slower instruction memory reached through a req/ack handshake. On a hit it returns the instruction combinationally in the same cycle. On a miss it asserts `stall` and refills the whole line from backing memory, one word per handshake. The core uses `stall` to hold its PC and IF/ID registers.

## Interface
Parameters:
- `LINES`, 16: number of cache lines; power of two, ≥2.
- `WORDS`, 4: 32-bit words per line; power of two, ≥2.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high reset.
- `pc` in 32: fetch byte address from the core; bits [1:0] are ignored.
- `instr` out 32: instruction at `pc` when `stall`=0; otherwise 32'h0000_0000 (NOP).
- `stall` out 1: high whenever `instr` is not valid for the current `pc`.
- `flush` in 1: invalidate all lines; sampled on `clk`.
- `mem_req` out 1: refill read request (registered).
- `mem_addr` out 32: word address of the request, word-aligned (registered).
- `mem_ack` in 1: memory accepts the request; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 32: refill data.
- `hit_count` out 32: present only with `ICACHE_STATS_EN`.
- `miss_count` out 32: present only with `ICACHE_STATS_EN`.

## Operation
- **Address split:**
  - offset = `pc[log2(WORDS)+1:2]`.
  - index = next log2(LINES) bits.
  - tag = the remaining upper bits.
- **Storage per line:** valid bit, tag, and WORDS data words.
- **FSM states:** IDLE and REFILL.
- **IDLE:**
  - Hit = valid[index] & tag match. On a hit, `instr` = data[index][offset] and `stall`=0, both combinational.
  - On a miss, `stall`=1. Latch the line base (`pc` with offset and byte bits zeroed), clear valid[index], clear the word counter, and go to REFILL.
- **REFILL:**
  - `mem_req`=1 and `mem_addr` = base + 4×counter.
  - Both are held stable until `mem_ack` is sampled high.
  - On ack, write `mem_rdata` into data[index][counter] and increment the counter.
  - On the ack for the last word (counter = WORDS−1), write the tag, set valid (unless `flush` was seen during this refill), drop `mem_req`, and return to IDLE.
  - `stall`=1 throughout REFILL.
- **`pc` change during REFILL:** the refill finishes for the latched line; the new `pc` is looked up in IDLE afterwards.
- **`flush`:**
  - Clears every valid bit at the next edge.
  - If asserted during REFILL, the handshake sequence still completes, but the refilled line is left invalid.
  - `flush` together with a miss in IDLE: the flush wins and no refill starts that cycle.
- **Reset (including mid-refill):**
  - All valid bits cleared, FSM to IDLE, counter 0.
  - `mem_req`=0 and `mem_addr`=0 immediately (asynchronous).
  - Counters are cleared.
  - Data and tag arrays are not reset.
- **Outputs after reset:** `stall`=1 and `instr`=0 (every line misses); `hit_count`=`miss_count`=0.

## Timing
- **Hit:** zero-cycle latency (same-cycle combinational path from `pc` to `instr`).
- **Miss with `mem_ack` tied high:**
  - Cycle 0: miss detected.
  - Cycles 1..WORDS: one request per cycle.
  - Cycle WORDS+1: IDLE, hit, `stall`=0.
  - Penalty = WORDS+1 cycles.
- **Miss with ack latency:** each word occupies at least one cycle; penalty = 1 + Σ(cycles per word).
- **Handshake:** a transfer happens on any rising edge where `mem_req`=1 and `mem_ack`=1. The next word's request is presented in the following cycle.

## Configuration
- **`ICACHE_STATS_EN` defined:**
  - `hit_count` increments each cycle that is in IDLE with a hit and `reset` low.
  - `miss_count` increments once per IDLE→REFILL transition.
  - Both counters are 32-bit, wrap at 2^32, and are cleared only by `reset`.
- **`ICACHE_STATS_EN` undefined:** the ports and counters are absent. All other behaviour is identical.

## Test plan
- **Cold miss:** reset, `pc`=0x0, memory returns word k = 0xA000_0000+k with ack tied high.
  - `stall`=1 for 5 cycles.
  - `mem_addr` = 0x0, 0x4, 0x8, 0xC.
  - Then `instr`=0xA000_0000 and `stall`=0.
- **Same-line hit:** after the cold miss, `pc`=0x8.
  - `instr`=0xA000_0002 in the same cycle, `stall`=0, and no `mem_req`.
- **Conflict miss:** with default parameters, 0x100 maps to index 0 with a different tag.
  - `pc`=0x100 → refill from 0x100..0x10C.
  - Then `pc`=0x0 misses again and refetches 0x0..0xC.
- **Slow memory:** ack asserted on the 3rd cycle of each request.
  - `mem_addr` stays stable while unacked.
  - `stall` lasts 1+4×3 = 13 cycles.
  - Correct data results.
- **Flush and reset mid-refill:**
  - Flush after word 1: the refill completes 4 handshakes, the same `pc` then misses again.
  - Reset after word 2: `mem_req` drops immediately and `stall`=1.
- **Stats (`ICACHE_STATS_EN`):** cold miss plus 3 hit cycles → `miss_count`=1, `hit_count`=3. Reset → both 0.
